msrv32_ifetch_queue: RTL

- Instruction-fetch stage directly downstream of the PC register; consumes its current-PC output.
- Issues in-order requests to instruction memory over a req/gnt + rvalid protocol.
- Tags each returned word with its PC and buffers it in a small FIFO for decode.
- Back-pressures the PC register through pc_advance_out; handles branch/trap flushes by discarding in-flight responses.

---
 rtl/msrv32_ifetch_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/msrv32_ifetch_queue.sv
// Instruction-fetch queue sitting directly after the PC register.
// Issues in-order fetches over req/gnt + rvalid, tags each returned word with
// its PC, buffers it for decode and drops responses made stale by a flush.
//
// Handshakes:
//   imem_req_out/imem_gnt_in : a request transfers in a cycle where both are
//     high; imem_addr_out is pc_in and pc_advance_out pulses in that cycle.
//   instr_valid_out/instr_ready_in : the head transfers in a cycle where both
//     are high; the head stays stable while valid is high and ready is low.
module msrv32_ifetch_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance_out,
  input  logic              flush_in,
  output logic              imem_req_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  input  logic              imem_gnt_in,
  input  logic              imem_rvalid_in,
  input  logic [31:0]       imem_rdata_in,
  output logic              instr_valid_out,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc_out,
  input  logic              instr_ready_in,
  output logic              misaligned_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_S = (CW + 1)'(DEPTH);

  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard_cnt;
  logic [CW-1:0]     live;
  logic [PW-1:0]     q_wr, q_rd;
  logic [PW-1:0]     f_wr, f_rd;
  logic [31:0]       q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [ADDR_W-1:0] f_pc   [DEPTH];

  logic room, can_issue, aligned, grant, resp, push, pop;

  // Issue decision, handshake strobes and head presentation.
  always_comb begin
    live = outstanding - discard_cnt;
    // Every live fetch already owns a queue slot, so a kept response never
    // overflows. Outstanding is also capped at DEPTH because fetches still
    // awaiting discard occupy the in-flight PC FIFO.
    room      = ({1'b0, count} + {1'b0, live}) < DEPTH_S;
    aligned   = (pc_in[1:0] == 2'b00);
    can_issue = !rst_in && !flush_in && room && (outstanding < DEPTH_C);

    imem_req_out   = can_issue && aligned;
    misaligned_out = can_issue && !aligned;
    imem_addr_out  = pc_in;

    grant          = imem_req_out && imem_gnt_in;
    pc_advance_out = grant;

    // A response with nothing outstanding is a protocol violation: ignored.
    resp = imem_rvalid_in && (outstanding != '0);
    push = resp && (discard_cnt == '0) && !flush_in;

    instr_valid_out = (count != '0);
    instr_out       = q_data[q_rd];
    instr_pc_out    = q_pc[q_rd];
    pop             = instr_valid_out && instr_ready_in && !flush_in;
  end

  // Occupancy, in-flight accounting and pointer updates.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count       <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      f_wr        <= '0;
      f_rd        <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(resp);
      if (grant) f_wr <= f_wr + PW'(1);
      if (resp)  f_rd <= f_rd + PW'(1);

      if (flush_in) begin
        // Everything still in flight after this cycle is stale.
        discard_cnt <= outstanding - CW'(resp);
        count       <= '0;
        q_wr        <= '0;
        q_rd        <= '0;
      end else begin
        if (resp && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (push) q_wr <= q_wr + PW'(1);
        if (pop)  q_rd <= q_rd + PW'(1);
      end
    end
  end

  // Storage: in-flight PC tags and the decode queue entries.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
        f_pc[i]   <= '0;
      end
    end else begin
      if (grant) f_pc[f_wr] <= pc_in;
      if (push) begin
        q_data[q_wr] <= imem_rdata_in;
        q_pc[q_wr]   <= f_pc[f_rd];
      end
    end
  end

endmodule
